regfile_wb_queue: RTL and testbench

Write-side front end for the 32 x 32 register file. It merges single-cycle write-back from the pipeline with results from multi-cycle units (divider, future load unit) onto the register file's single write port. Multi-cycle results are held in a small FIFO until a free write slot appears. A 32-entry scoreboard tracks registers with an outstanding multi-cycle write so the ID stage can stall readers.

---
 rtl/regfile_wb_queue.sv | 158 +++++++++++++++
 tb/tb_regfile_wb_queue.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// Write-side front end for the register file: merges pipeline write-back with queued
// multi-cycle results onto one write port and keeps a pending-write scoreboard.
// Optional feature macro: WB_QUEUE_BYPASS_EN (an accepted result skips the empty FIFO).
module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_wreg_i,
  input  logic [ADDR_W-1:0] wb_waddr_i,
  input  logic [DATA_W-1:0] wb_wdata_i,
  input  logic              mc_issue_i,
  input  logic [ADDR_W-1:0] mc_issue_addr_i,
  input  logic              mc_valid_i,
  output logic              mc_ready_o,
  input  logic [ADDR_W-1:0] mc_waddr_i,
  input  logic [DATA_W-1:0] mc_wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic              busy1_o,
  output logic              busy2_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 1 << ADDR_W;

  logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
  logic [DATA_W-1:0] r_fifo_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [NREG-1:0]   r_sb;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_push_fifo;
  logic              w_pop;
  logic              w_wb_win;
  logic              w_bypass;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_nxt_we;
  logic [ADDR_W-1:0] w_nxt_waddr;
  logic [DATA_W-1:0] w_nxt_wdata;
  logic [NREG-1:0]   w_sb_set;
  logic [NREG-1:0]   w_sb_clr;
  logic [NREG-1:0]   w_sb_nxt;
  logic [CNT_W-1:0]  w_count_nxt;

  // ---- Stage: FIFO status and arbitration (combinational) ----
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign mc_ready_o  = rst & ~w_full;
  assign w_push      = mc_valid_i & mc_ready_o;
  assign w_wb_win    = wb_wreg_i & (wb_waddr_i != '0);
  assign w_pop       = ~w_wb_win & ~w_empty;
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

`ifdef WB_QUEUE_BYPASS_EN
  assign w_bypass = w_push & w_empty & ~w_wb_win;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push_fifo = w_push & ~w_bypass;

  always_comb begin
    w_nxt_we    = 1'b0;
    w_nxt_waddr = r_waddr;
    w_nxt_wdata = r_wdata;
    if (w_wb_win) begin
      w_nxt_we    = 1'b1;
      w_nxt_waddr = wb_waddr_i;
      w_nxt_wdata = wb_wdata_i;
    end else if (w_pop) begin
      // A popped $0 entry still frees its slot but never reaches the register file.
      w_nxt_we    = (w_head_addr != '0);
      w_nxt_waddr = w_head_addr;
      w_nxt_wdata = w_head_data;
    end else if (w_bypass) begin
      w_nxt_we    = (mc_waddr_i != '0);
      w_nxt_waddr = mc_waddr_i;
      w_nxt_wdata = mc_wdata_i;
    end
  end

  always_comb begin
    w_sb_set = '0;
    w_sb_clr = '0;
    if (mc_issue_i && (mc_issue_addr_i != '0))
      w_sb_set = NREG'(1) << mc_issue_addr_i;
    if (w_pop && (w_head_addr != '0))
      w_sb_clr = NREG'(1) << w_head_addr;
    else if (w_bypass && (mc_waddr_i != '0))
      w_sb_clr = NREG'(1) << mc_waddr_i;
    // Set is applied after clear so a re-issue in the retiring cycle stays pending.
    w_sb_nxt = (r_sb & ~w_sb_clr) | w_sb_set;
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_fifo, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // ---- Stage: registered state (control and output port) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_sb     <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      if (w_push_fifo)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_sb    <= w_sb_nxt;
      r_we    <= w_nxt_we;
      r_waddr <= w_nxt_waddr;
      r_wdata <= w_nxt_wdata;
    end
  end

  // FIFO storage holds data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push_fifo) begin
      r_fifo_addr[r_wr_ptr] <= mc_waddr_i;
      r_fifo_data[r_wr_ptr] <= mc_wdata_i;
    end
  end

  // ---- Stage: outputs ----
  assign we_o    = r_we;
  assign waddr_o = r_waddr;
  assign wdata_o = r_wdata;
  assign busy1_o = r_sb[raddr1_i] & (raddr1_i != '0);
  assign busy2_o = r_sb[raddr2_i] & (raddr2_i != '0);

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed scenarios then random traffic,
// compared each cycle against a queue-based reference model.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_wreg_i;
  logic [AW-1:0] wb_waddr_i;
  logic [DW-1:0] wb_wdata_i;
  logic          mc_issue_i;
  logic [AW-1:0] mc_issue_addr_i;
  logic          mc_valid_i;
  logic          mc_ready_o;
  logic [AW-1:0] mc_waddr_i;
  logic [DW-1:0] mc_wdata_i;
  logic [AW-1:0] raddr1_i;
  logic [AW-1:0] raddr2_i;
  logic          busy1_o;
  logic          busy2_o;
  logic          we_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] wdata_o;

  regfile_wb_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .wb_wreg_i(wb_wreg_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .mc_issue_i(mc_issue_i), .mc_issue_addr_i(mc_issue_addr_i),
    .mc_valid_i(mc_valid_i), .mc_ready_o(mc_ready_o),
    .mc_waddr_i(mc_waddr_i), .mc_wdata_i(mc_wdata_i),
    .raddr1_i(raddr1_i), .raddr2_i(raddr2_i),
    .busy1_o(busy1_o), .busy2_o(busy2_o),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  int            n_assert = 0;
  int            n_fail   = 0;
  ent_t          mq[$];
  bit [31:0]     msb;
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    msb     = '0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic idle();
    wb_wreg_i       = 1'b0;
    wb_waddr_i      = '0;
    wb_wdata_i      = '0;
    mc_issue_i      = 1'b0;
    mc_issue_addr_i = '0;
    mc_valid_i      = 1'b0;
    mc_waddr_i      = '0;
    mc_wdata_i      = '0;
  endtask

  // One clock cycle: check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    bit   rdy;
    bit   push;
    bit   wbwin;
    ent_t h;
    #1;
    rdy = (mq.size() != DEPTH);
    chk("mc_ready", 64'(mc_ready_o), 64'(rdy));
    chk("busy1_pre", 64'(busy1_o), 64'((raddr1_i != '0) && msb[raddr1_i]));
    chk("busy2_pre", 64'(busy2_o), 64'((raddr2_i != '0) && msb[raddr2_i]));
    push  = mc_valid_i && rdy;
    wbwin = wb_wreg_i && (wb_waddr_i != '0);
    if (wbwin) begin
      m_we    = 1'b1;
      m_waddr = wb_waddr_i;
      m_wdata = wb_wdata_i;
    end else if (mq.size() > 0) begin
      h       = mq.pop_front();
      m_we    = (h.a != '0);
      m_waddr = h.a;
      m_wdata = h.d;
      if (h.a != '0) msb[h.a] = 1'b0;
    end
`ifdef WB_QUEUE_BYPASS_EN
    else if (push) begin
      m_we    = (mc_waddr_i != '0);
      m_waddr = mc_waddr_i;
      m_wdata = mc_wdata_i;
      if (mc_waddr_i != '0) msb[mc_waddr_i] = 1'b0;
      push = 1'b0;
    end
`endif
    else begin
      m_we = 1'b0;
    end
    if (push) begin
      h.a = mc_waddr_i;
      h.d = mc_wdata_i;
      mq.push_back(h);
    end
    if (mc_issue_i && (mc_issue_addr_i != '0)) msb[mc_issue_addr_i] = 1'b1;
    @(posedge clk);
    #1;
    chk("we", 64'(we_o), 64'(m_we));
    if (m_we) begin
      chk("waddr", 64'(waddr_o), 64'(m_waddr));
      chk("wdata", 64'(wdata_o), 64'(m_wdata));
    end
    chk("busy1_post", 64'(busy1_o), 64'((raddr1_i != '0) && msb[raddr1_i]));
    chk("busy2_post", 64'(busy2_o), 64'((raddr2_i != '0) && msb[raddr2_i]));
  endtask

  // Called 1 time unit after a rising edge; drops rst mid-cycle and checks the async clear.
  task automatic async_reset(input logic [AW-1:0] probe);
    idle();
    raddr1_i = probe;
    #3;
    rst = 1'b0;
    #1;
    chk("rst_we", 64'(we_o), 64'(0));
    chk("rst_waddr", 64'(waddr_o), 64'(0));
    chk("rst_wdata", 64'(wdata_o), 64'(0));
    chk("rst_ready", 64'(mc_ready_o), 64'(0));
    chk("rst_busy", 64'(busy1_o), 64'(0));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    raddr1_i = '0;
    raddr2_i = '0;
    idle();
    model_reset();
    #12;
    chk("init_we", 64'(we_o), 64'(0));
    chk("init_waddr", 64'(waddr_o), 64'(0));
    chk("init_wdata", 64'(wdata_o), 64'(0));
    chk("init_ready", 64'(mc_ready_o), 64'(0));
    #10;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Idle after release
    chk("idle_ready", 64'(mc_ready_o), 64'(1));
    raddr1_i = 5'd8;
    raddr2_i = 5'd9;
    cycle();
    cycle();
    chk("idle_we", 64'(we_o), 64'(0));

    // Pipeline write to $3, then a dropped write to $0
    wb_wreg_i  = 1'b1;
    wb_waddr_i = 5'd3;
    wb_wdata_i = 32'h11;
    cycle();
    chk("wb3_we", 64'(we_o), 64'(1));
    chk("wb3_addr", 64'(waddr_o), 64'(3));
    chk("wb3_data", 64'(wdata_o), 64'h11);
    wb_waddr_i = 5'd0;
    wb_wdata_i = 32'h55;
    cycle();
    chk("wb0_we", 64'(we_o), 64'(0));
    idle();

    // Issue $8, push its result while the pipeline writes for 3 cycles
    raddr1_i        = 5'd8;
    mc_issue_i      = 1'b1;
    mc_issue_addr_i = 5'd8;
    cycle();
    mc_issue_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_wreg_i  = 1'b1;
      wb_waddr_i = AW'(i + 1);
      wb_wdata_i = $urandom;
      mc_valid_i = (i == 0);
      mc_waddr_i = 5'd8;
      mc_wdata_i = 32'hDEAD;
      cycle();
      chk("busy8_held", 64'(busy1_o), 64'(1));
    end
    idle();
    cycle();
    chk("dead_we", 64'(we_o), 64'(1));
    chk("dead_addr", 64'(waddr_o), 64'(8));
    chk("dead_data", 64'(wdata_o), 64'hDEAD);
    chk("busy8_clr", 64'(busy1_o), 64'(0));

    // Fill the FIFO with no drain slot, hold a 5th result, then drain in order
    for (int i = 0; i < 5; i++) begin
      wb_wreg_i  = 1'b1;
      wb_waddr_i = AW'(20 + i);
      wb_wdata_i = $urandom;
      mc_valid_i = 1'b1;
      mc_waddr_i = AW'(10 + i);
      mc_wdata_i = 32'hA000 + 32'(i);
      cycle();
    end
    chk("full_ready", 64'(mc_ready_o), 64'(0));
    wb_wreg_i = 1'b0;
    cycle();
    chk("first_pop_addr", 64'(waddr_o), 64'(10));
    chk("ready_back", 64'(mc_ready_o), 64'(1));
    cycle();
    mc_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("drain_last", 64'(waddr_o), 64'(14));

    // Re-issue $9 in the cycle the old $9 result pops
    idle();
    raddr1_i        = 5'd9;
    mc_issue_i      = 1'b1;
    mc_issue_addr_i = 5'd9;
    cycle();
    mc_issue_i = 1'b0;
    wb_wreg_i  = 1'b1;
    wb_waddr_i = 5'd4;
    wb_wdata_i = 32'h44;
    mc_valid_i = 1'b1;
    mc_waddr_i = 5'd9;
    mc_wdata_i = 32'h99;
    cycle();
    idle();
    mc_issue_i      = 1'b1;
    mc_issue_addr_i = 5'd9;
    cycle();
    chk("reissue_we", 64'(we_o), 64'(1));
    chk("reissue_addr", 64'(waddr_o), 64'(9));
    chk("reissue_busy9", 64'(busy1_o), 64'(1));
    idle();

    // Queue 3 results behind pipeline writes, then reset asynchronously
    for (int i = 0; i < 3; i++) begin
      wb_wreg_i       = 1'b1;
      wb_waddr_i      = 5'd1;
      wb_wdata_i      = $urandom;
      mc_issue_i      = 1'b1;
      mc_issue_addr_i = AW'(20 + i);
      mc_valid_i      = 1'b1;
      mc_waddr_i      = AW'(20 + i);
      mc_wdata_i      = $urandom;
      cycle();
    end
    async_reset(5'd20);
    raddr1_i = 5'd20;
    raddr2_i = 5'd21;
    for (int i = 0; i < 4; i++) cycle();
    chk("post_rst_we", 64'(we_o), 64'(0));

    // Random traffic, with one mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset(AW'($urandom));
      wb_wreg_i       = ($urandom % 2) == 0;
      wb_waddr_i      = AW'($urandom);
      wb_wdata_i      = $urandom;
      mc_issue_i      = ($urandom % 4) == 0;
      mc_issue_addr_i = AW'($urandom);
      mc_valid_i      = ($urandom % 3) != 0;
      mc_waddr_i      = AW'($urandom % 8);
      mc_wdata_i      = $urandom;
      raddr1_i        = AW'($urandom % 8);
      raddr2_i        = AW'($urandom);
      cycle();
    end
    idle();
    for (int i = 0; i < DEPTH + 2; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
